// File: rtl/cwp_pkg.sv
// Shared types and helpers for the register-window controller: op and state encodings,
// the CWP +/-1 wrap step and the WIM rotation applied after a spill or fill.
package cwp_pkg;

    typedef enum logic {
        OP_SAVE    = 1'b0,
        OP_RESTORE = 1'b1
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam int         MAX_NWIN       = 32;
    localparam int         CWP_MAX_W      = 5;
    localparam logic [7:0] TRAP_COUNT_MAX = 8'd255;

    // nwin need not be a power of two, so both wraps are explicit compares
    function automatic logic [CWP_MAX_W-1:0] cwp_step(input logic [CWP_MAX_W-1:0] cur,
                                                      input op_e op, input int nwin);
        logic [CWP_MAX_W-1:0] last;
        last = CWP_MAX_W'(nwin - 1);
        if (op == OP_SAVE) begin
            if (cur == 5'd0) return last;
            else             return cur - 5'd1;
        end else begin
            if (cur == last) return 5'd0;
            else             return cur + 5'd1;
        end
    endfunction

    // SAVE moves bit i to i-1, RESTORE moves bit i to i+1, both modulo nwin
    function automatic logic [MAX_NWIN-1:0] wim_rotate(input logic [MAX_NWIN-1:0] w,
                                                       input op_e op, input int nwin);
        logic [MAX_NWIN-1:0] r;
        r = '0;
        for (int j = 0; j < MAX_NWIN; j++) begin
            if (j < nwin) begin
                if (op == OP_SAVE) r[j] = w[(j == nwin - 1) ? 0 : j + 1];
                else               r[j] = w[(j == 0) ? nwin - 1 : j - 1];
            end else begin
                r[j] = 1'b0;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/cwp_step_unit.sv
// Combinational next-window calculation: cwp -1 (SAVE) or +1 (RESTORE) modulo NWINDOWS.
module cwp_step_unit
    import cwp_pkg::*;
#(
    parameter int NWINDOWS = 8,
    parameter int CWP_W    = $clog2(NWINDOWS)
) (
    input  logic [CWP_W-1:0] cwp,
    input  op_e              op,
    output logic [CWP_W-1:0] cwp_next
);

    assign cwp_next = CWP_W'(cwp_step(CWP_MAX_W'(cwp), op, NWINDOWS));

endmodule

// File: rtl/cwp_window_ctrl.sv
// Owner of CWP and WIM; SAVE/RESTORE that land on an invalid window spill/fill it over the
// memory handshake before committing. Optional trap counter enabled by CWP_TRAP_COUNT_EN.
module cwp_window_ctrl
    import cwp_pkg::*;
#(
    parameter int NWINDOWS    = 8,
    parameter int CWP_W       = $clog2(NWINDOWS),
    parameter int SPILL_WORDS = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_op,
    input  logic                wim_load,
    input  logic [NWINDOWS-1:0] wim_data,
    output logic [CWP_W-1:0]    cwp,
    output logic [NWINDOWS-1:0] wim,
    output logic                resp_valid,
    output logic                resp_trap,
    output logic                mem_valid,
    input  logic                mem_ready,
    output logic                mem_write,
    output logic [CWP_W-1:0]    mem_win,
    output logic [3:0]          mem_idx
`ifdef CWP_TRAP_COUNT_EN
    ,
    output logic [7:0]          trap_count
`endif
);

    localparam logic [NWINDOWS-1:0] WIM_RST  = {1'b1, {(NWINDOWS-1){1'b0}}};
    localparam logic [3:0]          LAST_IDX = 4'(SPILL_WORDS - 1);

    state_e               state_r, state_n;
    op_e                  op_r, op_n, req_op_s;
    logic [CWP_W-1:0]     cwp_r, cwp_n, new_r, new_n, new_s;
    logic [NWINDOWS-1:0]  wim_r, wim_n, wim_rot_s;
    logic [3:0]           idx_r, idx_n;
    logic                 mem_valid_r, mem_valid_n, mem_write_r, mem_write_n;
    logic                 resp_valid_r, resp_valid_n, resp_trap_r, resp_trap_n;

    assign req_op_s  = op_e'(req_op);
    assign req_ready = (state_r == S_IDLE) & ~wim_load;
    assign wim_rot_s = NWINDOWS'(wim_rotate(MAX_NWIN'(wim_r), op_r, NWINDOWS));

    cwp_step_unit #(.NWINDOWS(NWINDOWS), .CWP_W(CWP_W)) u_step (
        .cwp      (cwp_r),
        .op       (req_op_s),
        .cwp_next (new_s)
    );

    // Next-state and next-output decode for the request/transfer FSM
    always_comb begin
        state_n      = state_r;
        op_n         = op_r;
        cwp_n        = cwp_r;
        new_n        = new_r;
        wim_n        = wim_r;
        idx_n        = idx_r;
        mem_valid_n  = mem_valid_r;
        mem_write_n  = mem_write_r;
        resp_valid_n = 1'b0;
        resp_trap_n  = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (wim_load) begin
                    wim_n = wim_data;
                end else if (req_valid) begin
                    op_n  = req_op_s;
                    new_n = new_s;
                    if (wim_r[new_s]) begin
                        state_n     = S_XFER;
                        idx_n       = 4'd0;
                        mem_valid_n = 1'b1;
                        mem_write_n = (req_op_s == OP_SAVE);
                    end else begin
                        state_n      = S_DONE;
                        cwp_n        = new_s;
                        resp_valid_n = 1'b1;
                    end
                end else begin
                    state_n = S_IDLE;
                end
            end
            S_XFER: begin
                // mem_valid is always high here, so mem_ready alone is the handshake
                if (mem_ready) begin
                    if (idx_r == LAST_IDX) begin
                        state_n      = S_DONE;
                        cwp_n        = new_r;
                        wim_n        = wim_rot_s;
                        idx_n        = 4'd0;
                        mem_valid_n  = 1'b0;
                        mem_write_n  = 1'b0;
                        resp_valid_n = 1'b1;
                        resp_trap_n  = 1'b1;
                    end else begin
                        idx_n = idx_r + 4'd1;
                    end
                end else begin
                    idx_n = idx_r;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any transfer without committing
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= S_IDLE;
            op_r         <= OP_SAVE;
            cwp_r        <= '0;
            new_r        <= '0;
            wim_r        <= WIM_RST;
            idx_r        <= 4'd0;
            mem_valid_r  <= 1'b0;
            mem_write_r  <= 1'b0;
            resp_valid_r <= 1'b0;
            resp_trap_r  <= 1'b0;
        end else begin
            state_r      <= state_n;
            op_r         <= op_n;
            cwp_r        <= cwp_n;
            new_r        <= new_n;
            wim_r        <= wim_n;
            idx_r        <= idx_n;
            mem_valid_r  <= mem_valid_n;
            mem_write_r  <= mem_write_n;
            resp_valid_r <= resp_valid_n;
            resp_trap_r  <= resp_trap_n;
        end
    end

    assign cwp        = cwp_r;
    assign wim        = wim_r;
    assign resp_valid = resp_valid_r;
    assign resp_trap  = resp_trap_r;
    assign mem_valid  = mem_valid_r;
    assign mem_write  = mem_write_r;
    assign mem_win    = new_r;
    assign mem_idx    = idx_r;

`ifdef CWP_TRAP_COUNT_EN
    logic [7:0] trap_count_r;
    logic       trap_done_s;

    assign trap_done_s = (state_r == S_XFER) & mem_ready & (idx_r == LAST_IDX);

    // Saturating count of completed spill/fill traps, visible alongside the response pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            trap_count_r <= 8'd0;
        end else if (trap_done_s && (trap_count_r != TRAP_COUNT_MAX)) begin
            trap_count_r <= trap_count_r + 8'd1;
        end else begin
            trap_count_r <= trap_count_r;
        end
    end

    assign trap_count = trap_count_r;
`endif

endmodule

// File: tb/tb_cwp_window_ctrl.sv
// Self-checking bench: an 8-window and a 5-window instance driven by directed and random
// SAVE/RESTORE traffic, compared against an arithmetic model of CWP, WIM and the transfers.
module tb_cwp_window_ctrl;

    localparam int SPILL = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid [2];
    logic       req_op    [2];
    logic       wim_load  [2];
    logic       mem_ready [2];
    logic [7:0] wim_data  [2];
    logic       req_ready_o [2];
    logic       resp_valid_o[2];
    logic       resp_trap_o [2];
    logic       mem_valid_o [2];
    logic       mem_write_o [2];
    logic [2:0] cwp_o       [2];
    logic [2:0] mem_win_o   [2];
    logic [3:0] mem_idx_o   [2];
    logic [7:0] wim8;
    logic [4:0] wim5;
`ifdef CWP_TRAP_COUNT_EN
    logic [7:0] tc_o [2];
`endif

    int          vectors     = 0;
    int          miscompares = 0;
    int          nw   [2] = '{8, 5};
    int          m_cwp[2];
    logic [31:0] m_wim[2];
    int          m_tc [2];

    always #5 clk = ~clk;

    cwp_window_ctrl #(.NWINDOWS(8), .SPILL_WORDS(SPILL)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready_o[0]),
        .req_op(req_op[0]), .wim_load(wim_load[0]), .wim_data(wim_data[0]),
        .cwp(cwp_o[0]), .wim(wim8), .resp_valid(resp_valid_o[0]), .resp_trap(resp_trap_o[0]),
        .mem_valid(mem_valid_o[0]), .mem_ready(mem_ready[0]), .mem_write(mem_write_o[0]),
        .mem_win(mem_win_o[0]), .mem_idx(mem_idx_o[0])
`ifdef CWP_TRAP_COUNT_EN
        , .trap_count(tc_o[0])
`endif
    );

    cwp_window_ctrl #(.NWINDOWS(5), .SPILL_WORDS(SPILL)) dut5 (
        .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready_o[1]),
        .req_op(req_op[1]), .wim_load(wim_load[1]), .wim_data(wim_data[1][4:0]),
        .cwp(cwp_o[1]), .wim(wim5), .resp_valid(resp_valid_o[1]), .resp_trap(resp_trap_o[1]),
        .mem_valid(mem_valid_o[1]), .mem_ready(mem_ready[1]), .mem_write(mem_write_o[1]),
        .mem_win(mem_win_o[1]), .mem_idx(mem_idx_o[1])
`ifdef CWP_TRAP_COUNT_EN
        , .trap_count(tc_o[1])
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] o_wim(input int k);
        return (k == 0) ? {24'd0, wim8} : {27'd0, wim5};
    endfunction

    function automatic logic [31:0] wmask(input int k);
        return (32'd1 << nw[k]) - 32'd1;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            req_valid[k] = 1'b0; req_op[k] = 1'b0; wim_load[k] = 1'b0;
            mem_ready[k] = 1'b0; wim_data[k] = 8'd0;
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_cwp[k] = 0;
            m_wim[k] = 32'd1 << (nw[k] - 1);
            m_tc[k]  = 0;
        end
    endtask

    task automatic chk_quiet(input int k);
        chk("q_cwp", {29'd0, cwp_o[k]}, m_cwp[k]);
        chk("q_wim", o_wim(k), m_wim[k]);
        chk("q_mem_valid", {31'd0, mem_valid_o[k]}, 32'd0);
        chk("q_resp_valid", {31'd0, resp_valid_o[k]}, 32'd0);
        chk("q_req_ready", {31'd0, req_ready_o[k]}, 32'd1);
`ifdef CWP_TRAP_COUNT_EN
        chk("q_trap_count", {24'd0, tc_o[k]}, m_tc[k]);
`endif
    endtask

    // stall: 0 never, 1 random, 2 three cycles at word 5
    task automatic do_req(input int k, input bit op, input bit ld, input logic [7:0] ldv,
                          input int stall);
        int nc, words, stalls, budget;
        bit trap, rdy;
        @(negedge clk);
        if (ld) begin
            wim_load[k] = 1'b1; wim_data[k] = ldv; req_valid[k] = 1'b1; req_op[k] = op;
            #1 chk("ready_during_load", {31'd0, req_ready_o[k]}, 32'd0);
            @(negedge clk);
            wim_load[k] = 1'b0;
            m_wim[k] = {24'd0, ldv} & wmask(k);
            chk("wim_loaded", o_wim(k), m_wim[k]);
        end
        req_valid[k] = 1'b1; req_op[k] = op;
        #1 chk("req_ready", {31'd0, req_ready_o[k]}, 32'd1);
        nc   = (m_cwp[k] + (op ? 1 : -1) + nw[k]) % nw[k];
        trap = m_wim[k][nc];
        @(negedge clk);
        req_valid[k] = 1'b0;
        if (trap) begin
            words = 0; stalls = 0; budget = 0;
            while (words < SPILL && budget < 200) begin
                chk("mem_valid", {31'd0, mem_valid_o[k]}, 32'd1);
                chk("mem_win", {29'd0, mem_win_o[k]}, nc);
                chk("mem_write", {31'd0, mem_write_o[k]}, {31'd0, ~op});
                chk("mem_idx", {28'd0, mem_idx_o[k]}, words);
                chk("early_resp", {31'd0, resp_valid_o[k]}, 32'd0);
                if (stall == 1)                            rdy = ($urandom_range(0, 3) != 0);
                else if (stall == 2 && words == 5 && stalls < 3) rdy = 1'b0;
                else                                       rdy = 1'b1;
                if (!rdy) stalls++;
                mem_ready[k] = rdy;
                @(negedge clk);
                if (rdy) words++;
                budget++;
            end
            mem_ready[k] = 1'b0;
            chk("xfer_words", words, SPILL);
            if (stall == 2) chk("stall_cycles", stalls, 3);
            if (op) m_wim[k] = ((m_wim[k] << 1) | (m_wim[k] >> (nw[k] - 1))) & wmask(k);
            else    m_wim[k] = (m_wim[k] >> 1) | ((m_wim[k] & 32'd1) << (nw[k] - 1));
            if (m_tc[k] < 255) m_tc[k]++;
        end
        m_cwp[k] = nc;
        chk("resp_valid", {31'd0, resp_valid_o[k]}, 32'd1);
        chk("resp_trap", {31'd0, resp_trap_o[k]}, {31'd0, trap});
        chk("cwp", {29'd0, cwp_o[k]}, m_cwp[k]);
        chk("wim", o_wim(k), m_wim[k]);
        chk("mem_valid_done", {31'd0, mem_valid_o[k]}, 32'd0);
        @(negedge clk);
        chk_quiet(k);
    endtask

    initial begin
        do_reset();
        chk_quiet(0);
        chk_quiet(1);

        // SAVE from cwp 0 onto the reset-invalid window 7: full spill
        do_req(0, 1'b0, 1'b0, 8'h00, 0);
        chk("spill_cwp7", {29'd0, cwp_o[0]}, 32'd7);
        chk("spill_wim40", o_wim(0), 32'h40);

        // wim=0x01 then seven RESTOREs walk cwp 1..7 without traps
        do_reset();
        do_req(0, 1'b1, 1'b1, 8'h01, 0);
        for (int i = 0; i < 6; i++) do_req(0, 1'b1, 1'b0, 8'h00, 0);
        chk("restore_walk_cwp7", {29'd0, cwp_o[0]}, 32'd7);

        // Trap with a three-cycle stall at word 5
        do_req(0, 1'b0, 1'b1, 8'h40, 2);

        // Reset at word 9 of a spill aborts it
        do_reset();
        @(negedge clk);
        req_valid[0] = 1'b1; req_op[0] = 1'b0;
        @(negedge clk);
        req_valid[0] = 1'b0; mem_ready[0] = 1'b1;
        repeat (9) @(negedge clk);
        chk("abort_idx9", {28'd0, mem_idx_o[0]}, 32'd9);
        rst = 1'b1; mem_ready[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_resp", {31'd0, resp_valid_o[0]}, 32'd0);
        chk("abort_cwp", {29'd0, cwp_o[0]}, 32'd0);
        chk("abort_wim", o_wim(0), 32'h80);
        chk("abort_mem_valid", {31'd0, mem_valid_o[0]}, 32'd0);
        @(negedge clk);
        chk_quiet(0);

        // Five windows: wrap 4 -> 0 on RESTORE, 0 -> 4 on SAVE, then a trap
        do_req(1, 1'b1, 1'b1, 8'h00, 0);
        for (int i = 0; i < 3; i++) do_req(1, 1'b1, 1'b0, 8'h00, 0);
        chk("n5_cwp4", {29'd0, cwp_o[1]}, 32'd4);
        do_req(1, 1'b1, 1'b0, 8'h00, 0);
        chk("n5_wrap0", {29'd0, cwp_o[1]}, 32'd0);
        do_req(1, 1'b0, 1'b0, 8'h00, 0);
        chk("n5_wrap4", {29'd0, cwp_o[1]}, 32'd4);
        do_req(1, 1'b0, 1'b1, 8'h08, 1);
        chk("n5_trap_wim", o_wim(1), 32'h04);

        // Random traffic with random WIM loads and stalls
        for (int i = 0; i < 60; i++)
            do_req(i % 5 == 4 ? 1 : 0, 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 3) == 0), 8'($urandom_range(0, 255)), 1);

`ifdef CWP_TRAP_COUNT_EN
        // All-ones WIM: every SAVE/RESTORE traps; counter saturates
        do_reset();
        for (int i = 0; i < 300; i++) begin
            do_req(0, 1'b0, (i == 0), 8'hFF, 0);
            do_req(0, 1'b1, 1'b0, 8'h00, 0);
        end
        chk("trap_count_sat", {24'd0, tc_o[0]}, 32'd255);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
